// File: rtl/cai_mctx_doorbell.sv
// Multi-context CAI doorbell controller: per-context submit ring config,
// doorbell latching, round-robin grant onto one valid/ready submit channel,
// and per-context completion coalescing into level interrupts.
module cai_mctx_doorbell #(
  parameter int N_CTX  = 4,
  parameter int ADDR_W = 64,
  parameter int RING_W = 32,
  parameter int CTX_W  = $clog2(N_CTX),
  parameter int COAL_W = 8,
  parameter int TMO_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CTX_W-1:0]  cfg_ctx,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [RING_W-1:0] cfg_size,
  output logic              cfg_err,
  output logic [N_CTX-1:0]  cfg_locked,
  input  logic              db_valid,
  input  logic [CTX_W-1:0]  db_ctx,
  output logic              sub_valid,
  input  logic              sub_ready,
  output logic [CTX_W-1:0]  sub_ctx,
  output logic [ADDR_W-1:0] sub_base,
  output logic [RING_W-1:0] sub_size,
  input  logic              comp_valid,
  input  logic [CTX_W-1:0]  comp_ctx,
  input  logic [COAL_W-1:0] coal_thresh,
  input  logic [TMO_W-1:0]  coal_tmo,
  output logic [N_CTX-1:0]  comp_irq,
  input  logic [N_CTX-1:0]  irq_ack
);

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t            state_q, state_d;
  logic [N_CTX-1:0]  pending_q, pending_d;
  logic [ADDR_W-1:0] base_q [N_CTX];
  logic [RING_W-1:0] size_q [N_CTX];
  logic [CTX_W-1:0]  rr_ptr_q;
  logic              err_q;

  logic              vld_p1;
  logic [CTX_W-1:0]  sub_ctx_p1;
  logic [ADDR_W-1:0] sub_base_p1;
  logic [RING_W-1:0] sub_size_p1;

  logic [N_CTX-1:0]  locked_c, db_hit, db_set, cfg_wr, comp_hit, hs_clr;
  logic              db_rej, cfg_rej, handshake;

  logic              grant_vld;
  logic [CTX_W-1:0]  grant_idx, idx;
  logic [ADDR_W-1:0] grant_base;
  logic [RING_W-1:0] grant_size;

  logic [COAL_W-1:0] cnt_q [N_CTX];
  logic [COAL_W-1:0] cnt_inc [N_CTX];
  logic [COAL_W-1:0] cnt_d [N_CTX];
  logic [TMO_W-1:0]  tmr_q [N_CTX];
  logic [TMO_W-1:0]  tmr_d [N_CTX];
  logic [N_CTX-1:0]  fire, irq_q;
  logic [COAL_W-1:0] thresh_eff;

  // Saturating +1 so a flood of completions cannot wrap the counter.
  function automatic logic [COAL_W-1:0] sat_inc(input logic [COAL_W-1:0] v,
                                                input logic inc);
    if (inc && (v != {COAL_W{1'b1}})) return v + COAL_W'(1);
    return v;
  endfunction

  // Round-robin pointer advance past the context just served.
  function automatic logic [CTX_W-1:0] ctx_next(input logic [CTX_W-1:0] c);
    if (int'(c) >= N_CTX - 1) return '0;
    return c + CTX_W'(1);
  endfunction

  assign handshake  = vld_p1 & sub_ready;
  assign sub_valid  = vld_p1;
  assign sub_ctx    = sub_ctx_p1;
  assign sub_base   = sub_base_p1;
  assign sub_size   = sub_size_p1;
  assign cfg_err    = err_q;
  assign cfg_locked = locked_c;
  assign comp_irq   = irq_q;

  // Per-context decode of config writes, doorbells, completions and handshake.
  always_comb begin
    locked_c = '0;
    db_hit   = '0;
    db_set   = '0;
    cfg_wr   = '0;
    comp_hit = '0;
    hs_clr   = '0;
    for (int i = 0; i < N_CTX; i++) begin
      locked_c[i] = pending_q[i] | (vld_p1 & (sub_ctx_p1 == CTX_W'(i)));
      db_hit[i]   = db_valid & (db_ctx == CTX_W'(i));
      db_set[i]   = db_hit[i] & (size_q[i] != '0);
      cfg_wr[i]   = cfg_we & (cfg_ctx == CTX_W'(i)) & ~locked_c[i] & ~db_hit[i];
      comp_hit[i] = comp_valid & (comp_ctx == CTX_W'(i));
      hs_clr[i]   = handshake & (sub_ctx_p1 == CTX_W'(i));
    end
    db_rej    = db_valid & ~(|db_set);
    cfg_rej   = cfg_we & ~(|cfg_wr);
    // A doorbell landing with the handshake of its own context keeps it pending.
    pending_d = (pending_q & ~hs_clr) | db_set;
  end

  // Arbiter next state and round-robin search starting at rr_ptr.
  always_comb begin
    state_d    = state_q;
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_base = '0;
    grant_size = '0;
    idx        = '0;
    for (int k = 0; k < N_CTX; k++) begin
      idx = CTX_W'((int'(rr_ptr_q) + k) % N_CTX);
      if (!grant_vld && pending_q[idx]) begin
        grant_vld  = 1'b1;
        grant_idx  = idx;
        grant_base = base_q[idx];
        grant_size = size_q[idx];
      end
    end
    case (state_q)
      S_IDLE:  if (grant_vld) state_d = S_OFFER;
      S_OFFER: if (sub_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Arbiter state, pending set and the registered submit offer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      vld_p1      <= 1'b0;
      sub_ctx_p1  <= '0;
      sub_base_p1 <= '0;
      sub_size_p1 <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      // stage p1: offer registered from the grant, held until accepted
      if (state_q == S_IDLE && grant_vld) begin
        vld_p1      <= 1'b1;
        sub_ctx_p1  <= grant_idx;
        sub_base_p1 <= grant_base;
        sub_size_p1 <= grant_size;
      end else if (handshake) begin
        vld_p1   <= 1'b0;
        rr_ptr_q <= ctx_next(sub_ctx_p1);
      end
    end
  end

  // Ring configuration storage and the rejection pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      for (int i = 0; i < N_CTX; i++) begin
        base_q[i] <= '0;
        size_q[i] <= '0;
      end
    end else begin
      err_q <= db_rej | cfg_rej;
      for (int i = 0; i < N_CTX; i++) begin
        if (cfg_wr[i]) begin
          base_q[i] <= cfg_base;
          size_q[i] <= cfg_size;
        end
      end
    end
  end

  // Coalescing decision: count threshold or idle timeout per context.
  always_comb begin
    thresh_eff = (coal_thresh == '0) ? COAL_W'(1) : coal_thresh;
    for (int i = 0; i < N_CTX; i++) begin
      cnt_inc[i] = sat_inc(cnt_q[i], comp_hit[i]);
      fire[i]    = (cnt_inc[i] >= thresh_eff) |
                   ((coal_tmo != '0) & (cnt_q[i] != '0) &
                    (tmr_q[i] == coal_tmo - TMO_W'(1)));
      cnt_d[i]   = fire[i] ? '0 : cnt_inc[i];
      tmr_d[i]   = (fire[i] | comp_hit[i] | (cnt_q[i] == '0)) ? '0
                                                               : tmr_q[i] + TMO_W'(1);
    end
  end

  // Coalescing counters, timers and level interrupts (fire beats ack).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= '0;
      for (int i = 0; i < N_CTX; i++) begin
        cnt_q[i] <= '0;
        tmr_q[i] <= '0;
      end
    end else begin
      irq_q <= fire | (irq_q & ~irq_ack);
      for (int i = 0; i < N_CTX; i++) begin
        cnt_q[i] <= cnt_d[i];
        tmr_q[i] <= tmr_d[i];
      end
    end
  end

endmodule
